// File: rtl/multdiv_arbiter.sv
// Two-requester round-robin front end for a shared multiply/divide unit.
// One operation is in flight at a time: grant, issue pulse, wait for result or timeout, respond.
module multdiv_arbiter #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        clr_n,
  input  logic        a_req_valid,
  input  logic        a_req_op,
  input  logic [31:0] a_req_opA,
  input  logic [31:0] a_req_opB,
  output logic        a_req_ready,
  input  logic        b_req_valid,
  input  logic        b_req_op,
  input  logic [31:0] b_req_opA,
  input  logic [31:0] b_req_opB,
  output logic        b_req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_exception,
  input  logic        rsp_ready,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_b_q, last_b_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] md_opA_q, md_opA_d;
  logic [31:0] md_opB_q, md_opB_d;
  logic        mult_q, mult_d;
  logic        div_q, div_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_exc_q, rsp_exc_d;
  logic        busy_q, busy_d;
  logic        grant_a, grant_b;

  // Handshakes: a request transfers in the cycle *_req_valid & *_req_ready are both 1;
  // a response transfers in the cycle rsp_valid & rsp_ready are both 1.
  // On a tie the requester that was not served last wins; ready is gated by reset.
  assign grant_a = (state_q == IDLE) && clr_n && a_req_valid && (!b_req_valid || last_b_q);
  assign grant_b = (state_q == IDLE) && clr_n && b_req_valid && (!a_req_valid || !last_b_q);

  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    cnt_d        = cnt_q;
    md_opA_d     = md_opA_q;
    md_opB_d     = md_opB_q;
    mult_d       = 1'b0;
    div_d        = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_exc_d    = rsp_exc_q;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (grant_a || grant_b) begin
          state_d  = ISSUE;
          busy_d   = 1'b1;
          rsp_id_d = grant_b;
          md_opA_d = grant_b ? b_req_opA : a_req_opA;
          md_opB_d = grant_b ? b_req_opB : a_req_opB;
          mult_d   = grant_b ? !b_req_op : !a_req_op;
          div_d    = grant_b ? b_req_op : a_req_op;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 6'd0;
      end
      WAIT: begin
        cnt_d = cnt_q + 6'd1;
        // A result arriving on the timeout cycle takes priority over the timeout.
        if (md_resultRDY) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = md_result;
          rsp_exc_d    = md_exception;
        end else if (cnt_q == TO_LAST) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = 32'd0;
          rsp_exc_d    = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          last_b_d    = rsp_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= IDLE;
      last_b_q     <= 1'b1;
      cnt_q        <= 6'd0;
      md_opA_q     <= 32'd0;
      md_opB_q     <= 32'd0;
      mult_q       <= 1'b0;
      div_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_exc_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_b_q     <= last_b_d;
      cnt_q        <= cnt_d;
      md_opA_q     <= md_opA_d;
      md_opB_q     <= md_opB_d;
      mult_q       <= mult_d;
      div_q        <= div_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_exc_q    <= rsp_exc_d;
      busy_q       <= busy_d;
    end
  end

  assign a_req_ready   = grant_a;
  assign b_req_ready   = grant_b;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_exception = rsp_exc_q;
  assign md_opA        = md_opA_q;
  assign md_opB        = md_opB_q;
  assign md_ctrl_MULT  = mult_q;
  assign md_ctrl_DIV   = div_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Directed bench for multdiv_arbiter with a small behavioural multiply/divide unit
// that answers a configurable number of cycles after each start pulse.
module tb_multdiv_arbiter;

  logic        clock = 1'b0;
  logic        clr_n;
  logic        a_req_valid, a_req_op, b_req_valid, b_req_op;
  logic [31:0] a_req_opA, a_req_opB, b_req_opA, b_req_opB;
  logic        a_req_ready, b_req_ready;
  logic        rsp_valid, rsp_id, rsp_exception, rsp_ready;
  logic [31:0] rsp_result, md_opA, md_opB, md_result;
  logic        md_ctrl_MULT, md_ctrl_DIV, md_exception, md_resultRDY, busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural unit controls
  int  unit_lat = 3;
  bit  unit_on  = 1'b1;
  bit  pend     = 1'b0;
  int  cnt      = 0;

  multdiv_arbiter #(.TIMEOUT(40)) dut (
    .clock(clock), .clr_n(clr_n),
    .a_req_valid(a_req_valid), .a_req_op(a_req_op), .a_req_opA(a_req_opA),
    .a_req_opB(a_req_opB), .a_req_ready(a_req_ready),
    .b_req_valid(b_req_valid), .b_req_op(b_req_op), .b_req_opA(b_req_opA),
    .b_req_opB(b_req_opB), .b_req_ready(b_req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_exception(rsp_exception), .rsp_ready(rsp_ready),
    .md_opA(md_opA), .md_opB(md_opB), .md_ctrl_MULT(md_ctrl_MULT),
    .md_ctrl_DIV(md_ctrl_DIV), .md_result(md_result), .md_exception(md_exception),
    .md_resultRDY(md_resultRDY), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- behavioural multdiv unit ----------------
  initial begin
    md_result    = 32'd0;
    md_exception = 1'b0;
    md_resultRDY = 1'b0;
  end

  always @(posedge clock) begin
    md_resultRDY <= 1'b0;
    if ((md_ctrl_MULT || md_ctrl_DIV) && unit_on) begin
      if (md_ctrl_MULT) begin
        md_result    <= md_opA * md_opB;
        md_exception <= 1'b0;
      end else if (md_opB == 32'd0) begin
        md_result    <= 32'hFFFF_FFFF;
        md_exception <= 1'b1;
      end else begin
        md_result    <= md_opA / md_opB;
        md_exception <= 1'b0;
      end
      if (unit_lat == 1) md_resultRDY <= 1'b1;
      else begin
        pend <= 1'b1;
        cnt  <= unit_lat - 1;
      end
    end else if (pend) begin
      if (cnt == 1) begin
        md_resultRDY <= 1'b1;
        pend         <= 1'b0;
      end
      cnt <= cnt - 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    clr_n = 1'b0;
    @(negedge clock);
    clr_n = 1'b1;
    tick();
  endtask

  task automatic drive_a(input logic op, input logic [31:0] x, input logic [31:0] y);
    a_req_valid = 1'b1;
    a_req_op    = op;
    a_req_opA   = x;
    a_req_opB   = y;
  endtask

  task automatic drive_b(input logic op, input logic [31:0] x, input logic [31:0] y);
    b_req_valid = 1'b1;
    b_req_op    = op;
    b_req_opA   = x;
    b_req_opB   = y;
  endtask

  // Bounded wait for rsp_valid; counts cycles and any start pulses seen meanwhile.
  task automatic wait_rsp(input int max, output int cyc, output int pulses, output bit ok);
    cyc = 0;
    pulses = 0;
    ok = 1'b0;
    while (cyc < max) begin
      tick();
      cyc++;
      if (md_ctrl_MULT || md_ctrl_DIV) pulses++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr_n = 1'b0;
    a_req_valid = 1'b1; a_req_op = 1'b0; a_req_opA = 32'd1; a_req_opB = 32'd1;
    b_req_valid = 1'b1; b_req_op = 1'b0; b_req_opA = 32'd1; b_req_opB = 32'd1;
    rsp_ready = 1'b0;
    #3;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_exception, busy, md_ctrl_MULT, md_ctrl_DIV, a_req_ready, b_req_ready} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000000",
               {rsp_valid, rsp_id, rsp_exception, busy, md_ctrl_MULT, md_ctrl_DIV, a_req_ready, b_req_ready});
    end
    n_checks++;
    if (rsp_result !== 32'd0 || md_opA !== 32'd0 || md_opB !== 32'd0 || dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h opA=%h opB=%h state=%0d want 0", rsp_result, md_opA, md_opB, dbg_state);
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    @(negedge clock);
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_single_mult();
    int cyc, pulses;
    bit ok;
    unit_lat = 3;
    unit_on = 1'b1;
    rsp_ready = 1'b0;
    drive_a(1'b0, 32'd6, 32'd7);
    #1;
    n_checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: a_ready=%b b_ready=%b want 1 0", a_req_ready, b_req_ready);
    end
    tick();
    a_req_valid = 1'b0;
    a_req_opA = 32'd99;
    n_checks++;
    if (md_ctrl_MULT !== 1'b1 || md_ctrl_DIV !== 1'b0 || md_opA !== 32'd6 || md_opB !== 32'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_issue: mult=%b div=%b opA=%0d opB=%0d busy=%b want 1 0 6 7 1",
               md_ctrl_MULT, md_ctrl_DIV, md_opA, md_opB, busy);
    end
    wait_rsp(20, cyc, pulses, ok);
    n_checks++;
    if (!ok || cyc !== 4 || pulses !== 0) begin
      n_fail++;
      $display("FAIL single_latency: ok=%b cycles=%0d extra_pulses=%0d want 1 4 0", ok, cyc, pulses);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd42 || rsp_exception !== 1'b0) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: valid=%b id=%b result=%0d exc=%b want 1 0 42 0",
                 i, rsp_valid, rsp_id, rsp_result, rsp_exception);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || md_opA !== 32'd6) begin
      n_fail++;
      $display("FAIL single_done: valid=%b busy=%b opA=%0d want 0 0 6", rsp_valid, busy, md_opA);
    end
  endtask

  task automatic test_round_robin();
    int cyc, pulses;
    bit ok;
    apply_reset();
    unit_lat = 3;
    drive_a(1'b1, 32'd100, 32'd7);
    drive_b(1'b0, 32'd3, 32'd5);
    #1;
    n_checks++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_first: a_ready=%b b_ready=%b want 1 0", a_req_ready, b_req_ready);
    end
    tick();
    a_req_valid = 1'b0;
    #1;
    n_checks++;
    if (md_ctrl_DIV !== 1'b1 || md_ctrl_MULT !== 1'b0 || md_opA !== 32'd100 || b_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_issue_a: div=%b mult=%b opA=%0d b_ready=%b want 1 0 100 0",
               md_ctrl_DIV, md_ctrl_MULT, md_opA, b_req_ready);
    end
    wait_rsp(20, cyc, pulses, ok);
    n_checks++;
    if (!ok || rsp_id !== 1'b0 || rsp_result !== 32'd14 || rsp_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_rsp_a: ok=%b id=%b result=%0d exc=%b want 1 0 14 0", ok, rsp_id, rsp_result, rsp_exception);
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (b_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_no_grant_on_rsp: b_ready=%b want 0", b_req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_checks++;
    if (b_req_ready !== 1'b1 || a_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_second: a_ready=%b b_ready=%b want 0 1", a_req_ready, b_req_ready);
    end
    tick();
    b_req_valid = 1'b0;
    n_checks++;
    if (md_ctrl_MULT !== 1'b1 || md_opA !== 32'd3 || md_opB !== 32'd5) begin
      n_fail++;
      $display("FAIL rr_issue_b: mult=%b opA=%0d opB=%0d want 1 3 5", md_ctrl_MULT, md_opA, md_opB);
    end
    wait_rsp(20, cyc, pulses, ok);
    n_checks++;
    if (!ok || rsp_id !== 1'b1 || rsp_result !== 32'd15) begin
      n_fail++;
      $display("FAIL rr_rsp_b: ok=%b id=%b result=%0d want 1 1 15", ok, rsp_id, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  n = 0;
    int  both = 0;
    int  gid[4];
    int  gcyc[4];
    logic [3:0] exp_ids;
    exp_ids = 4'b1010;
    apply_reset();
    unit_lat = 3;
    rsp_ready = 1'b1;
    drive_a(1'b0, 32'd4, 32'd5);
    drive_b(1'b1, 32'd20, 32'd4);
    for (int c = 0; c < 80 && n < 4; c++) begin
      if (c == 0) #1;
      else tick();
      if (a_req_ready && b_req_ready) both++;
      if (a_req_ready || b_req_ready) begin
        gid[n]  = b_req_ready ? 1 : 0;
        gcyc[n] = c;
        n++;
      end
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    n_checks++;
    if (n !== 4 || both !== 0) begin
      n_fail++;
      $display("FAIL b2b_grants: grants=%0d both_ready=%0d want 4 0", n, both);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (gid[i] !== int'(exp_ids[i])) begin
        n_fail++;
        $display("FAIL b2b_order[%0d]: id=%0d want %0d", i, gid[i], exp_ids[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (gcyc[i] - gcyc[i-1] !== 6) begin
          n_fail++;
          $display("FAIL b2b_spacing[%0d]: cycles=%0d want 6", i, gcyc[i] - gcyc[i-1]);
        end
      end
    end
    repeat (10) tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: busy=%b valid=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_div_zero();
    int cyc, pulses;
    bit ok;
    unit_lat = 2;
    drive_a(1'b1, 32'd5, 32'd0);
    tick();
    a_req_valid = 1'b0;
    wait_rsp(20, cyc, pulses, ok);
    n_checks++;
    if (!ok || rsp_exception !== 1'b1 || rsp_result !== 32'hFFFF_FFFF || cyc !== 3) begin
      n_fail++;
      $display("FAIL divzero_rsp: ok=%b exc=%b result=%h cycles=%0d want 1 1 ffffffff 3",
               ok, rsp_exception, rsp_result, cyc);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    drive_a(1'b0, 32'd9, 32'd9);
    tick();
    a_req_valid = 1'b0;
    wait_rsp(20, cyc, pulses, ok);
    n_checks++;
    if (!ok || rsp_exception !== 1'b0 || rsp_result !== 32'd81) begin
      n_fail++;
      $display("FAIL divzero_next: ok=%b exc=%b result=%0d want 1 0 81", ok, rsp_exception, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int waits = 0;
    int cyc = 0;
    unit_on = 1'b0;
    drive_a(1'b0, 32'd1, 32'd1);
    tick();
    a_req_valid = 1'b0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (dbg_state == 2'd2) waits++;
      if (rsp_valid) break;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || waits !== 40 || cyc !== 41) begin
      n_fail++;
      $display("FAIL timeout_len: valid=%b wait_cycles=%0d cycles=%0d want 1 40 41", rsp_valid, waits, cyc);
    end
    n_checks++;
    if (rsp_result !== 32'd0 || rsp_exception !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_rsp: result=%h exc=%b want 0 1", rsp_result, rsp_exception);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    unit_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cyc, pulses;
    bit ok;
    unit_on = 1'b0;
    unit_lat = 3;
    drive_a(1'b0, 32'd2, 32'd3);
    tick();
    tick();
    tick();
    n_checks++;
    if (dbg_state !== 2'd2) begin
      n_fail++;
      $display("FAIL midrst_in_wait: state=%0d want 2", dbg_state);
    end
    drive_a(1'b0, 32'd11, 32'd12);
    @(negedge clock);
    clr_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_exception, busy, md_ctrl_MULT, md_ctrl_DIV, a_req_ready, b_req_ready} !== 8'd0
        || rsp_result !== 32'd0 || md_opA !== 32'd0 || md_opB !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: flags=%b result=%h opA=%h opB=%h want all 0",
               {rsp_valid, rsp_id, rsp_exception, busy, md_ctrl_MULT, md_ctrl_DIV, a_req_ready, b_req_ready},
               rsp_result, md_opA, md_opB);
    end
    unit_on = 1'b1;
    @(negedge clock);
    clr_n = 1'b1;
    #1;
    n_checks++;
    if (a_req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_regrant: a_ready=%b valid=%b want 1 0", a_req_ready, rsp_valid);
    end
    tick();
    a_req_valid = 1'b0;
    n_checks++;
    if (md_ctrl_MULT !== 1'b1 || md_opA !== 32'd11 || md_opB !== 32'd12) begin
      n_fail++;
      $display("FAIL midrst_issue: mult=%b opA=%0d opB=%0d want 1 11 12", md_ctrl_MULT, md_opA, md_opB);
    end
    wait_rsp(20, cyc, pulses, ok);
    n_checks++;
    if (!ok || cyc !== 4 || rsp_result !== 32'd132 || rsp_id !== 1'b0 || rsp_exception !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_rsp: ok=%b cycles=%0d result=%0d id=%b exc=%b want 1 4 132 0 0",
               ok, cyc, rsp_result, rsp_id, rsp_exception);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_mult();
    test_round_robin();
    test_back_to_back();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
